postproc_simd_pipe: RTL

- Parametrised, pipelined successor to the combinational bias/ReLU stage between the systolic array outputs and O_buffer_top.
- Adds a per-channel bias register file, rounding right-shift requantisation, selectable activation (none / ReLU / clamped ReLU), saturation to a configurable output width, and a valid/ready handshake with backpressure.
- Processes one full row of ARRAY_M lanes per beat.

---
 rtl/postproc_simd_pipe_if.sv | 12 +
 rtl/postproc_simd_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/postproc_simd_pipe_if.sv
// Valid/ready stream bundle carrying one packed row of lanes per beat.
// The source side uses the master modport; the sink side uses slave.
interface postproc_simd_pipe_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/postproc_simd_pipe.sv
// Three-stage post-processing pipe for systolic array rows.
// Stages: bias add, rounding requantise shift, then activation and saturation. All stages stall together.
module postproc_simd_pipe #(
    parameter int ARRAY_M     = 16,
    parameter int IN_WIDTH    = 32,
    parameter int BIAS_WIDTH  = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    localparam int IDX_W      = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             cfg_act_mode,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [OUT_WIDTH-1:0]   cfg_clamp_max,
    input  logic                   bias_w_en,
    input  logic [IDX_W-1:0]       bias_w_index,
    input  logic [BIAS_WIDTH-1:0]  bias_w_data,
    input  logic                   bias_clear,
    postproc_simd_pipe_if.slave    in_if,
    postproc_simd_pipe_if.master   out_if,
    output logic                   sat_flag,
    input  logic                   sat_clear
);

    localparam int SUM_W = ((IN_WIDTH > BIAS_WIDTH) ? IN_WIDTH : BIAS_WIDTH) + 1;
    localparam int RND_W = SUM_W + 1;
    localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ACT_BYPASS  = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_CLAMP   = 2'd2,
        ACT_BYPASS3 = 2'd3
    } act_mode_e;

    logic signed [BIAS_WIDTH-1:0]  bias_r     [ARRAY_M];

    logic                          s1_valid_r;
    logic signed [SUM_W-1:0]       s1_sum_r   [ARRAY_M];
    act_mode_e                     s1_mode_r;
    logic [SHIFT_WIDTH-1:0]        s1_shift_r;
    logic [OUT_WIDTH-1:0]          s1_clamp_r;

    logic                          s2_valid_r;
    logic signed [RND_W-1:0]       s2_res_r   [ARRAY_M];
    act_mode_e                     s2_mode_r;
    logic [OUT_WIDTH-1:0]          s2_clamp_r;

    logic                          out_valid_r;
    logic [ARRAY_M*OUT_WIDTH-1:0]  out_data_r;
    logic                          s3_sat_r;
    logic                          sat_flag_r;

    logic                          advance_s;
    logic                          accept_s;
    logic signed [SUM_W-1:0]       sum_s      [ARRAY_M];
    logic [RND_W-1:0]              half_s;
    logic signed [RND_W-1:0]       rnd_s      [ARRAY_M];
    logic signed [RND_W-1:0]       clamp_ext_s;
    logic signed [RND_W-1:0]       act_s      [ARRAY_M];
    logic [ARRAY_M*OUT_WIDTH-1:0]  act_data_s;
    logic [ARRAY_M-1:0]            sat_lane_s;

    assign advance_s    = !out_valid_r || out_if.ready;
    assign accept_s     = in_if.valid && advance_s;
    assign in_if.ready  = advance_s;
    assign out_if.valid = out_valid_r;
    assign out_if.data  = out_data_r;
    assign sat_flag     = sat_flag_r;

    // Stage 1 datapath: sign-extended lane plus bias, one bit wider so it cannot overflow.
    always_comb begin
        for (int i = 0; i < ARRAY_M; i++) begin
            sum_s[i] = {{(SUM_W-IN_WIDTH){in_if.data[i*IN_WIDTH+IN_WIDTH-1]}}, in_if.data[i*IN_WIDTH +: IN_WIDTH]}
                     + {{(SUM_W-BIAS_WIDTH){bias_r[i][BIAS_WIDTH-1]}}, bias_r[i]};
        end
    end

    // Stage 2 datapath: round-half-up arithmetic shift with a guard bit for the rounding add.
    always_comb begin
        half_s = {RND_W{1'b0}};
        if (s1_shift_r != {SHIFT_WIDTH{1'b0}}) begin
            half_s = {{(RND_W-1){1'b0}}, 1'b1} << (s1_shift_r - {{(SHIFT_WIDTH-1){1'b0}}, 1'b1});
        end else begin
            half_s = {RND_W{1'b0}};
        end
        for (int i = 0; i < ARRAY_M; i++) begin
            rnd_s[i] = ($signed({s1_sum_r[i][SUM_W-1], s1_sum_r[i]}) + $signed(half_s)) >>> s1_shift_r;
        end
    end

    // Stage 3 datapath: activation first; mode 2 clamping is not reported as saturation.
    always_comb begin
        clamp_ext_s = {{(RND_W-OUT_WIDTH){s2_clamp_r[OUT_WIDTH-1]}}, s2_clamp_r};
        act_data_s  = {(ARRAY_M*OUT_WIDTH){1'b0}};
        sat_lane_s  = {ARRAY_M{1'b0}};
        for (int i = 0; i < ARRAY_M; i++) begin
            act_s[i] = s2_res_r[i];
            case (s2_mode_r)
                ACT_RELU: begin
                    if (s2_res_r[i][RND_W-1]) begin
                        act_s[i] = {RND_W{1'b0}};
                    end else begin
                        act_s[i] = s2_res_r[i];
                    end
                end
                ACT_CLAMP: begin
                    if (s2_res_r[i][RND_W-1]) begin
                        act_s[i] = {RND_W{1'b0}};
                    end else if (s2_res_r[i] > clamp_ext_s) begin
                        act_s[i] = clamp_ext_s;
                    end else begin
                        act_s[i] = s2_res_r[i];
                    end
                end
                default: act_s[i] = s2_res_r[i];
            endcase
            if (act_s[i] > SAT_MAX) begin
                act_data_s[i*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
                sat_lane_s[i] = 1'b1;
            end else if (act_s[i] < SAT_MIN) begin
                act_data_s[i*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
                sat_lane_s[i] = 1'b1;
            end else begin
                act_data_s[i*OUT_WIDTH +: OUT_WIDTH] = act_s[i][OUT_WIDTH-1:0];
                sat_lane_s[i] = 1'b0;
            end
        end
    end

    // Pipeline registers: every stage moves only when the output slot is free or being taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_mode_r   <= ACT_BYPASS;
            s1_shift_r  <= {SHIFT_WIDTH{1'b0}};
            s1_clamp_r  <= {OUT_WIDTH{1'b0}};
            s2_valid_r  <= 1'b0;
            s2_mode_r   <= ACT_BYPASS;
            s2_clamp_r  <= {OUT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {(ARRAY_M*OUT_WIDTH){1'b0}};
            s3_sat_r    <= 1'b0;
            for (int i = 0; i < ARRAY_M; i++) begin
                s1_sum_r[i] <= {SUM_W{1'b0}};
                s2_res_r[i] <= {RND_W{1'b0}};
            end
        end else if (advance_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_mode_r  <= act_mode_e'(cfg_act_mode);
                s1_shift_r <= cfg_shift;
                s1_clamp_r <= cfg_clamp_max;
                for (int i = 0; i < ARRAY_M; i++) begin
                    s1_sum_r[i] <= sum_s[i];
                end
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_mode_r  <= s1_mode_r;
                s2_clamp_r <= s1_clamp_r;
                for (int i = 0; i < ARRAY_M; i++) begin
                    s2_res_r[i] <= rnd_s[i];
                end
            end
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_data_r <= act_data_s;
                s3_sat_r   <= |sat_lane_s;
            end
        end
    end

    // Bias register file; indices with no matching lane fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARRAY_M; i++) begin
                bias_r[i] <= {BIAS_WIDTH{1'b0}};
            end
        end else if (bias_clear) begin
            for (int i = 0; i < ARRAY_M; i++) begin
                bias_r[i] <= {BIAS_WIDTH{1'b0}};
            end
        end else if (bias_w_en) begin
            for (int i = 0; i < ARRAY_M; i++) begin
                if (bias_w_index == IDX_W'(i)) begin
                    bias_r[i] <= bias_w_data;
                end
            end
        end
    end

    // Sticky saturation flag; a completing saturating beat wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag_r <= 1'b0;
        end else if (out_valid_r && out_if.ready && s3_sat_r) begin
            sat_flag_r <= 1'b1;
        end else if (sat_clear) begin
            sat_flag_r <= 1'b0;
        end
    end

endmodule
